adsr_envelope: RTL and testbench

ADSR_ENVELOPE -- requirements
Module: adsr_envelope

---
 rtl/synth_pkg.sv | 20 ++
 rtl/adsr_voice_step.sv | 80 ++++++++
 rtl/adsr_envelope.sv | 117 +++++++++++
 tb/tb_adsr_envelope.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the synthesizer envelope blocks.
package synth_pkg;

  localparam int unsigned N_VOICES       = 8;
  localparam logic [31:0] ENV_FULL_SCALE = 32'h0010_0000;

  typedef enum logic [2:0] {
    StIdle,
    StAttack,
    StDecay,
    StSustain,
    StRelease
  } env_state_t;

  // Sustain settings above unity gain are pinned to full scale.
  function automatic logic [31:0] clamp_level(input logic [31:0] v);
    return (v > ENV_FULL_SCALE) ? ENV_FULL_SCALE : v;
  endfunction

endpackage

// File: rtl/adsr_voice_step.sv
// Combinational next-state and next-level computation for one envelope voice.
module adsr_voice_step
  import synth_pkg::*;
(
  input  env_state_t  state,
  input  logic [31:0] level,
  input  logic        gate,
  input  logic        pend,
  input  logic [31:0] attack_step,
  input  logic [31:0] decay_step,
  input  logic [31:0] sustain_level,
  input  logic [31:0] release_step,
  output env_state_t  state_nxt,
  output logic [31:0] level_nxt
);

  logic [31:0] sus;
  logic [32:0] sum;
  logic [32:0] dec_diff;
  logic [32:0] rel_diff;
  logic        idle_or_rel;
  logic        trig;
  env_state_t  eff;

  always_comb begin
    sus         = clamp_level(sustain_level);
    idle_or_rel = (state == StIdle) || (state == StRelease);
    // A latched trigger with the key already lifted still restarts a silent or
    // releasing voice, but cannot override a release of a sounding one.
    trig        = gate ? (pend | idle_or_rel) : (pend & idle_or_rel);

    eff = state;
    if (trig) begin
      eff = StAttack;
    end else if (!gate && !idle_or_rel) begin
      eff = StRelease;
    end

    sum      = {1'b0, level} + {1'b0, attack_step};
    dec_diff = {1'b0, level} - {1'b0, decay_step};
    rel_diff = {1'b0, level} - {1'b0, release_step};

    state_nxt = eff;
    level_nxt = level;
    case (eff)
      StAttack: begin
        if ((attack_step == '0) || (sum >= {1'b0, ENV_FULL_SCALE})) begin
          level_nxt = ENV_FULL_SCALE;
          state_nxt = StDecay;
        end else begin
          level_nxt = sum[31:0];
        end
      end
      StDecay: begin
        if ((decay_step == '0) || dec_diff[32] || (dec_diff[31:0] <= sus)) begin
          level_nxt = sus;
          state_nxt = StSustain;
        end else begin
          level_nxt = dec_diff[31:0];
        end
      end
      StSustain: begin
        level_nxt = sus;
      end
      StRelease: begin
        if ((release_step == '0) || rel_diff[32] || (rel_diff[31:0] == '0)) begin
          level_nxt = '0;
          state_nxt = StIdle;
        end else begin
          level_nxt = rel_diff[31:0];
        end
      end
      default: begin
        level_nxt = '0;
        state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: rtl/adsr_envelope.sv
// Multi-voice ADSR envelope generator; one shared step unit serviced voice-by-voice
// in a sweep started by each tick.
module adsr_envelope #(
  parameter int unsigned N_VOICES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic [N_VOICES-1:0]      gate,
  input  logic [31:0]              attack_step,
  input  logic [31:0]              decay_step,
  input  logic [31:0]              sustain_level,
  input  logic [31:0]              release_step,
  output logic [N_VOICES-1:0][31:0] voice_volumes,
  output logic [N_VOICES-1:0]      active,
  output logic                     frame_done,
  output logic                     tick_overrun
);

  import synth_pkg::*;

  localparam int unsigned IdxW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int unsigned CntW = IdxW + 1;

  env_state_t                state_q [N_VOICES];
  logic [N_VOICES-1:0][31:0] level_q;
  logic [N_VOICES-1:0]       pend_q;
  logic [N_VOICES-1:0]       pend_d;
  logic [N_VOICES-1:0]       gate_prev_q;
  logic [N_VOICES-1:0]       trig_pend;
  logic                      busy_q;
  logic [CntW-1:0]           cnt_q;
  logic                      frame_done_q;
  logic                      overrun_q;

  logic                      start;
  logic                      svc_en;
  logic [IdxW-1:0]           svc_idx;
  env_state_t                svc_state;
  logic [31:0]               svc_level;
  env_state_t                step_state;
  logic [31:0]               step_level;

  // Voice 0 is serviced on the same edge that accepts the tick.
  assign start     = tick & ~busy_q;
  assign svc_en    = start | (busy_q & (cnt_q < CntW'(N_VOICES)));
  assign svc_idx   = busy_q ? cnt_q[IdxW-1:0] : '0;
  assign trig_pend = pend_q | (gate & ~gate_prev_q);
  assign svc_state = state_q[svc_idx];
  assign svc_level = level_q[svc_idx];

  adsr_voice_step u_step (
    .state         (svc_state),
    .level         (svc_level),
    .gate          (gate[svc_idx]),
    .pend          (trig_pend[svc_idx]),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .state_nxt     (step_state),
    .level_nxt     (step_level)
  );

  always_comb begin
    pend_d = trig_pend;
    if (svc_en) begin
      pend_d[svc_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_VOICES; i++) begin
        state_q[i] <= StIdle;
      end
      level_q      <= '0;
      pend_q       <= '0;
      gate_prev_q  <= '0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      gate_prev_q  <= gate;
      pend_q       <= pend_d;
      frame_done_q <= busy_q && (cnt_q == CntW'(N_VOICES));
      overrun_q    <= tick & busy_q;
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= CntW'(1);
      end else if (busy_q) begin
        if (cnt_q == CntW'(N_VOICES)) begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (svc_en) begin
        state_q[svc_idx] <= step_state;
        level_q[svc_idx] <= step_level;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_VOICES; i++) begin
      active[i] = (state_q[i] != StIdle);
    end
  end

  assign voice_volumes = level_q;
  assign frame_done    = frame_done_q;
  assign tick_overrun  = overrun_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed self-checking bench for adsr_envelope.
module tb_adsr_envelope;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic [7:0]       gate = '0;
  logic [31:0]      attack_step = '0;
  logic [31:0]      decay_step = '0;
  logic [31:0]      sustain_level = '0;
  logic [31:0]      release_step = '0;
  logic [7:0][31:0] voice_volumes;
  logic [7:0]       active;
  logic             frame_done;
  logic             tick_overrun;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  adsr_envelope #(.N_VOICES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .voice_volumes (voice_volumes),
    .active        (active),
    .frame_done    (frame_done),
    .tick_overrun  (tick_overrun)
  );

  // One tick, then wait until the sweep has fully completed.
  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (voice_volumes !== '0 || active !== 8'h00 || frame_done !== 1'b0 ||
        tick_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: vols=%h active=%h fd=%b ov=%b want all 0",
               voice_volumes, active, frame_done, tick_overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_attack();
    logic [31:0] exp_lvl [8] = '{32'h40000, 32'h80000, 32'hC0000, 32'h100000,
                                 32'hF0000, 32'hE0000, 32'hD0000, 32'hC0000};
    attack_step   = 32'h40000;
    decay_step    = 32'h10000;
    sustain_level = 32'hC0000;
    gate[0]       = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pulse_tick();
      tests_run++;
      if (voice_volumes[0] !== exp_lvl[k] || active[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL attack_tick%0d: level=%h active=%b want level=%h active=1",
                 k, voice_volumes[0], active[0], exp_lvl[k]);
      end
    end
    tests_run++;
    if (voice_volumes[1] !== 32'h0 || active[7:1] !== 7'h00) begin
      tests_failed++;
      $display("FAIL attack_other_voices: v1=%h active=%h want 0 / 01",
               voice_volumes[1], active);
    end
  endtask

  task automatic test_release();
    logic [31:0] exp_lvl [4] = '{32'h90000, 32'h60000, 32'h30000, 32'h0};
    logic        exp_act [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    release_step = 32'h30000;
    gate[0]      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse_tick();
      tests_run++;
      if (voice_volumes[0] !== exp_lvl[k] || active[0] !== exp_act[k]) begin
        tests_failed++;
        $display("FAIL release_tick%0d: level=%h active=%b want level=%h active=%b",
                 k, voice_volumes[0], active[0], exp_lvl[k], exp_act[k]);
      end
    end
  endtask

  task automatic test_short_gate();
    @(negedge clk) gate[3] = 1'b1;
    repeat (2) @(negedge clk);
    gate[3] = 1'b0;
    repeat (2) @(negedge clk);
    pulse_tick();
    tests_run++;
    if (voice_volumes[3] !== 32'h40000 || active[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL short_gate_attack: level=%h active=%b want 00040000 / 1",
               voice_volumes[3], active[3]);
    end
    pulse_tick();
    tests_run++;
    if (voice_volumes[3] !== 32'h10000 || active[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL short_gate_release: level=%h active=%b want 00010000 / 1",
               voice_volumes[3], active[3]);
    end
    pulse_tick();
    tests_run++;
    if (voice_volumes[3] !== 32'h0 || active[3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_gate_idle: level=%h active=%b want 0 / 0",
               voice_volumes[3], active[3]);
    end
  endtask

  // Tick at T, an overlapping tick at T+4 and a back-to-back tick at T+9.
  task automatic test_overrun_back_to_back();
    @(negedge clk) tick = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      tick = (c == 4) || (c == 9);
      tests_run++;
      if (tick_overrun !== (c == 5) || frame_done !== (c == 9 || c == 18)) begin
        tests_failed++;
        $display("FAIL overrun_cycle%0d: ov=%b fd=%b want ov=%b fd=%b", c,
                 tick_overrun, frame_done, (c == 5), (c == 9 || c == 18));
      end
    end
    tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_steps();
    attack_step   = 32'h0;
    decay_step    = 32'h0;
    sustain_level = 32'hC0000;
    gate[1]       = 1'b1;
    pulse_tick();
    tests_run++;
    if (voice_volumes[1] !== 32'h100000) begin
      tests_failed++;
      $display("FAIL zero_attack: level=%h want 00100000", voice_volumes[1]);
    end
    pulse_tick();
    tests_run++;
    if (voice_volumes[1] !== 32'hC0000) begin
      tests_failed++;
      $display("FAIL zero_decay: level=%h want 000c0000", voice_volumes[1]);
    end
    sustain_level = 32'h200000;
    pulse_tick();
    tests_run++;
    if (voice_volumes[1] !== 32'h100000) begin
      tests_failed++;
      $display("FAIL sustain_clamp: level=%h want 00100000", voice_volumes[1]);
    end
    release_step = 32'h0;
    gate[1]      = 1'b0;
    pulse_tick();
    tests_run++;
    if (voice_volumes[1] !== 32'h0 || active[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_release: level=%h active=%b want 0 / 0",
               voice_volumes[1], active[1]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    attack_step = 32'h40000;
    gate[2]     = 1'b1;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (voice_volumes[2] !== 32'h40000 || active[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_level: level=%h active=%b want 00040000 / 1",
               voice_volumes[2], active[2]);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (voice_volumes !== '0 || active !== 8'h00 || frame_done !== 1'b0 ||
        tick_overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: vols=%h active=%h fd=%b ov=%b want all 0",
               voice_volumes, active, frame_done, tick_overrun);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      tests_run++;
      if (frame_done !== 1'b0 || voice_volumes[2] !== 32'h0) begin
        tests_failed++;
        $display("FAIL no_partial_frame%0d: fd=%b level=%h want 0 / 0", c,
                 frame_done, voice_volumes[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_release();
    test_short_gate();
    test_overrun_back_to_back();
    test_zero_steps();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
